zynet_cfg_sequencer: RTL

- Streams pre-trained weights and biases from a single word stream into every neuron of the zyNet layers, in place of per-word host addressing.
- Sits between the host configuration path (AXI-lite write FIFO or DMA stream) and the neuron config bus: config_layer_num, config_neuron_num, weightValue/weightValid, biasValue/biasValid.
- Generates layer/neuron addressing internally from the network geometry and reports busy/done to the top-level control logic.

---
 rtl/zynet_cfg_sequencer_pkg.sv | 20 ++
 rtl/zynet_cfg_index_counter.sv | 65 ++++++
 rtl/zynet_cfg_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/zynet_cfg_sequencer_pkg.sv
// Shared constants and types for the zyNet weight/bias configuration sequencer.
// Geometry vectors are packed 16-bit fields, layer 1 in the LSBs.
package zynet_cfg_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 16;   // dataWidth
  localparam int GEO_W          = 16;
  localparam int LAYER_IDX_W    = 4;
  localparam int MAX_LAYERS     = 15;

  localparam logic [4*GEO_W-1:0] DEF_LAYER_NEURONS = {16'd10, 16'd10, 16'd30, 16'd30};
  localparam logic [4*GEO_W-1:0] DEF_LAYER_WEIGHTS = {16'd10, 16'd30, 16'd30, 16'd784};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WEIGHT,
    ST_BIAS,
    ST_DONE
  } cfg_state_t;

endpackage

// File: rtl/zynet_cfg_index_counter.sv
// Nested weight/neuron/layer index counter for the configuration sequencer.
// Reports the wrap conditions of the current indices so the FSM can steer.
module zynet_cfg_index_counter
  import zynet_cfg_sequencer_pkg::*;
#(
  parameter int                          NUM_LAYERS    = 4,
  parameter logic [NUM_LAYERS*GEO_W-1:0] LAYER_NEURONS = DEF_LAYER_NEURONS,
  parameter logic [NUM_LAYERS*GEO_W-1:0] LAYER_WEIGHTS = DEF_LAYER_WEIGHTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   step_weight,
  input  logic                   step_bias,
  output logic [GEO_W-1:0]       neuron,
  output logic [LAYER_IDX_W-1:0] layer,
  output logic                   weight_wrap,
  output logic                   neuron_wrap,
  output logic                   layer_last
);

  localparam logic [LAYER_IDX_W-1:0] LAST_LAYER = LAYER_IDX_W'(NUM_LAYERS - 1);

  logic [GEO_W-1:0] w_cnt;
  logic [GEO_W-1:0] n_tab [16];
  logic [GEO_W-1:0] w_tab [16];

  // Full 16-entry tables so the 4-bit layer index never runs off the end.
  for (genvar i = 0; i < 16; i++) begin : g_tab
    if (i < NUM_LAYERS) begin : g_used
      assign n_tab[i] = LAYER_NEURONS[i*GEO_W +: GEO_W];
      assign w_tab[i] = LAYER_WEIGHTS[i*GEO_W +: GEO_W];
    end else begin : g_pad
      assign n_tab[i] = 16'd1;
      assign w_tab[i] = 16'd1;
    end
  end

  assign weight_wrap = (w_cnt == w_tab[layer] - 16'd1);
  assign neuron_wrap = (neuron == n_tab[layer] - 16'd1);
  assign layer_last  = (layer == LAST_LAYER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_cnt  <= '0;
      neuron <= '0;
      layer  <= '0;
    end else if (clear) begin
      w_cnt  <= '0;
      neuron <= '0;
      layer  <= '0;
    end else if (step_weight) begin
      w_cnt <= w_cnt + 16'd1;
    end else if (step_bias) begin
      w_cnt <= '0;
      if (!neuron_wrap) begin
        neuron <= neuron + 16'd1;
      end else if (!layer_last) begin
        neuron <= '0;
        layer  <= layer + 4'd1;
      end
    end
  end

endmodule

// File: rtl/zynet_cfg_sequencer.sv
// Streams weights then bias for every neuron of every layer from one word
// stream onto the neuron config bus, generating layer/neuron addresses itself.
module zynet_cfg_sequencer
  import zynet_cfg_sequencer_pkg::*;
#(
  parameter int                          DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int                          NUM_LAYERS    = 4,
  parameter logic [NUM_LAYERS*GEO_W-1:0] LAYER_NEURONS = DEF_LAYER_NEURONS,
  parameter logic [NUM_LAYERS*GEO_W-1:0] LAYER_WEIGHTS = DEF_LAYER_WEIGHTS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [15:0]           config_layer_num,
  output logic [15:0]           config_neuron_num,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic                  biasValid,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [31:0]           cfg_word_cnt
);

  if (NUM_LAYERS < 1 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_layers
    $error("zynet_cfg_sequencer: NUM_LAYERS=%0d outside 1..%0d", NUM_LAYERS, MAX_LAYERS);
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_geo_chk
    if (LAYER_NEURONS[i*GEO_W +: GEO_W] == 16'd0 ||
        LAYER_WEIGHTS[i*GEO_W +: GEO_W] == 16'd0) begin : g_bad
      $error("zynet_cfg_sequencer: layer %0d has zero neurons or weights", i + 1);
    end
  end

  cfg_state_t             state;
  logic [GEO_W-1:0]       neuron;
  logic [LAYER_IDX_W-1:0] layer;
  logic                   weight_wrap, neuron_wrap, layer_last;
  logic                   accept, start_ok;

  assign cfg_ready = (state == ST_WEIGHT) || (state == ST_BIAS);
  // Abort blocks both acceptance and start in the same cycle.
  assign accept    = cfg_valid && cfg_ready && !cfg_abort;
  assign start_ok  = (state == ST_IDLE) && cfg_start && !cfg_abort;

  zynet_cfg_index_counter #(
    .NUM_LAYERS    (NUM_LAYERS),
    .LAYER_NEURONS (LAYER_NEURONS),
    .LAYER_WEIGHTS (LAYER_WEIGHTS)
  ) u_idx (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_ok),
    .step_weight (accept && state == ST_WEIGHT),
    .step_bias   (accept && state == ST_BIAS),
    .neuron      (neuron),
    .layer       (layer),
    .weight_wrap (weight_wrap),
    .neuron_wrap (neuron_wrap),
    .layer_last  (layer_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      config_layer_num  <= 16'd1;
      config_neuron_num <= '0;
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= 1'b0;
      cfg_busy          <= 1'b0;
      cfg_done          <= 1'b0;
      cfg_word_cnt      <= '0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      cfg_done    <= 1'b0;

      // Address outputs carry the indices of the word being strobed.
      if (accept) begin
        config_layer_num  <= {12'd0, layer} + 16'd1;
        config_neuron_num <= neuron;
        cfg_word_cnt      <= cfg_word_cnt + 32'd1;
        if (state == ST_WEIGHT) begin
          weightValue <= cfg_data;
          weightValid <= 1'b1;
        end else begin
          biasValue <= cfg_data;
          biasValid <= 1'b1;
        end
      end

      if (cfg_abort) begin
        state    <= ST_IDLE;
        cfg_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_start) begin
              state        <= ST_WEIGHT;
              cfg_busy     <= 1'b1;
              cfg_word_cnt <= '0;
            end
          end
          ST_WEIGHT: begin
            if (accept && weight_wrap) state <= ST_BIAS;
          end
          ST_BIAS: begin
            if (accept) state <= (neuron_wrap && layer_last) ? ST_DONE : ST_WEIGHT;
          end
          ST_DONE: begin
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
